// File: rtl/game_round_timer.sv
// -----------------------------------------------------------------------------
// game_round_timer
//   Round timer for the GAME state. Loads a round length in seconds when GAME
//   is entered and counts it down with a clock prescaler. The countdown can be
//   frozen with pause. Each clicked_duck pulse adds a saturating time bonus.
//   Drives the HUD (seconds left, warning) and gives the main state machine a
//   one-cycle end_of_time pulse so it can leave GAME.
//
// Ports
//   clk           in   1      system clock
//   rst           in   1      asynchronous, active-high reset
//   state_in      in   2      current top-level game state
//   time_in       in   SEC_W  round length in seconds, sampled on round start
//   pause         in   1      level, high freezes the countdown
//   clicked_duck  in   1      one-cycle pulse per duck hit
//   secs_left     out  SEC_W  remaining whole seconds (registered)
//   sec_tick      out  1      one-cycle pulse per elapsed second (registered)
//   warning       out  1      low-time flag (registered)
//   running       out  1      high while counting or paused (registered)
//   end_of_time   out  1      one-cycle pulse when the round expires (registered)
// -----------------------------------------------------------------------------
module game_round_timer #(
  parameter int unsigned CLK_FREQ_HZ = 75_000_000,
  parameter int unsigned SEC_W       = 8,
  parameter int unsigned BONUS_S     = 2,
  parameter int unsigned WARN_S      = 5,
  parameter logic [1:0]  GAME        = 2'b10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       state_in,
  input  logic [SEC_W-1:0] time_in,
  input  logic             pause,
  input  logic             clicked_duck,
  output logic [SEC_W-1:0] secs_left,
  output logic             sec_tick,
  output logic             warning,
  output logic             running,
  output logic             end_of_time
);

  localparam int unsigned     PRE_W     = $clog2(CLK_FREQ_HZ);
  localparam logic [PRE_W-1:0] PRE_TC   = PRE_W'(CLK_FREQ_HZ - 1);
  localparam logic [SEC_W:0]  BONUS_EXT = (SEC_W+1)'(BONUS_S);
  localparam logic [SEC_W:0]  WARN_EXT  = (SEC_W+1)'(WARN_S);
  localparam logic [SEC_W:0]  ONE_EXT   = (SEC_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10,
    DONE   = 2'b11
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PRE_W-1:0]   presc;
  logic [PRE_W-1:0]   presc_nxt;
  logic [SEC_W-1:0]   secs_nxt;
  logic [SEC_W:0]     secs_sum;
  logic               tick_nxt;
  logic               eot_nxt;
  logic               run_nxt;
  logic               warn_nxt;

  // Clamp a one-bit-wider second count back into SEC_W bits.
  function automatic logic [SEC_W-1:0] sat_secs(input logic [SEC_W:0] v);
    logic [SEC_W-1:0] r;
    if (v[SEC_W]) begin
      r = {SEC_W{1'b1}};
    end else begin
      r = v[SEC_W-1:0];
    end
    return r;
  endfunction

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic plus next values of the prescaler and every output.
  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    secs_nxt  = secs_left;
    secs_sum  = {1'b0, secs_left};
    tick_nxt  = 1'b0;
    eot_nxt   = 1'b0;

    if (state_in != GAME) begin
      // Leaving GAME always wins and discards any pending expiry.
      state_nxt = IDLE;
      presc_nxt = {PRE_W{1'b0}};
      secs_nxt  = {SEC_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          presc_nxt = {PRE_W{1'b0}};
          secs_nxt  = time_in;
          if (time_in != {SEC_W{1'b0}}) begin
            state_nxt = RUN;
          end else begin
            state_nxt = DONE;
            eot_nxt   = 1'b1;
          end
        end
        RUN, PAUSED: begin
          if (clicked_duck) begin
            secs_sum = {1'b0, secs_left} + BONUS_EXT;
          end else begin
            secs_sum = {1'b0, secs_left};
          end
          if (pause) begin
            // Frozen: prescaler holds and no tick is produced this cycle.
            state_nxt = PAUSED;
          end else begin
            // An un-paused cycle counts, including the cycle that leaves PAUSED.
            state_nxt = RUN;
            if (presc == PRE_TC) begin
              presc_nxt = {PRE_W{1'b0}};
              tick_nxt  = 1'b1;
              secs_sum  = secs_sum - ONE_EXT;
            end else begin
              presc_nxt = presc + PRE_W'(1);
            end
          end
          secs_nxt = sat_secs(secs_sum);
          // A bonus landing on the final tick keeps the round alive.
          if (tick_nxt && (secs_nxt == {SEC_W{1'b0}})) begin
            state_nxt = DONE;
            eot_nxt   = 1'b1;
          end else begin
            eot_nxt   = 1'b0;
          end
        end
        DONE: begin
          presc_nxt = {PRE_W{1'b0}};
          secs_nxt  = {SEC_W{1'b0}};
        end
        default: begin
          state_nxt = IDLE;
          presc_nxt = {PRE_W{1'b0}};
          secs_nxt  = {SEC_W{1'b0}};
        end
      endcase
    end

    run_nxt  = (state_nxt == RUN) || (state_nxt == PAUSED);
    warn_nxt = run_nxt && (secs_nxt != {SEC_W{1'b0}}) &&
               ({1'b0, secs_nxt} <= WARN_EXT);
  end

  // Prescaler and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc       <= {PRE_W{1'b0}};
      secs_left   <= {SEC_W{1'b0}};
      sec_tick    <= 1'b0;
      warning     <= 1'b0;
      running     <= 1'b0;
      end_of_time <= 1'b0;
    end else begin
      presc       <= presc_nxt;
      secs_left   <= secs_nxt;
      sec_tick    <= tick_nxt;
      warning     <= warn_nxt;
      running     <= run_nxt;
      end_of_time <= eot_nxt;
    end
  end

endmodule

// File: tb/tb_game_round_timer.sv
// -----------------------------------------------------------------------------
// tb_game_round_timer
//   Directed bench for game_round_timer with CLK_FREQ_HZ=10, SEC_W=4,
//   BONUS_S=2, WARN_S=2. Inputs change 1 ns after a rising edge and outputs are
//   checked at that same point, so "RUN+n" means n edges after RUN entry.
// -----------------------------------------------------------------------------
module tb_game_round_timer;

  localparam logic [1:0] GAME_ST = 2'b10;
  localparam logic [1:0] MENU_ST = 2'b00;

  logic       clk;
  logic       rst;
  logic [1:0] state_in;
  logic [3:0] time_in;
  logic       pause;
  logic       clicked_duck;
  logic [3:0] secs_left;
  logic       sec_tick;
  logic       warning;
  logic       running;
  logic       end_of_time;

  int total;
  int bad;
  int ticks;
  int eots;

  game_round_timer #(
    .CLK_FREQ_HZ(10),
    .SEC_W      (4),
    .BONUS_S    (2),
    .WARN_S     (2),
    .GAME       (2'b10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .state_in    (state_in),
    .time_in     (time_in),
    .pause       (pause),
    .clicked_duck(clicked_duck),
    .secs_left   (secs_left),
    .sec_tick    (sec_tick),
    .warning     (warning),
    .running     (running),
    .end_of_time (end_of_time)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance n edges, accumulating tick and end_of_time pulses seen.
  task automatic steps(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (sec_tick) ticks++;
      if (end_of_time) eots++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_secs"}, 32'(secs_left), 32'd0);
    chk({tag, "_tick"}, 32'(sec_tick), 32'd0);
    chk({tag, "_warn"}, 32'(warning), 32'd0);
    chk({tag, "_run"},  32'(running), 32'd0);
    chk({tag, "_eot"},  32'(end_of_time), 32'd0);
  endtask

  initial begin
    total = 0; bad = 0; ticks = 0; eots = 0;
    rst = 1'b1; state_in = MENU_ST; time_in = 4'd0; pause = 1'b0; clicked_duck = 1'b0;
    #12;
    chk_all_zero("reset");
    step();
    rst = 1'b0;
    step();
    chk_all_zero("idle");

    // 1: plain countdown of 3 s
    time_in = 4'd3; state_in = GAME_ST;
    step();                                   // RUN+0
    chk("t1_load", 32'(secs_left), 32'd3);
    chk("t1_run0", 32'(running), 32'd1);
    chk("t1_warn0", 32'(warning), 32'd0);
    ticks = 0; eots = 0;
    steps(9);                                 // RUN+9
    chk("t1_noearlytick", 32'(ticks), 32'd0);
    step();                                   // RUN+10
    chk("t1_tick10", 32'(sec_tick), 32'd1);
    chk("t1_secs10", 32'(secs_left), 32'd2);
    chk("t1_warn10", 32'(warning), 32'd1);
    step();                                   // RUN+11
    chk("t1_tickw", 32'(sec_tick), 32'd0);
    steps(9);                                 // RUN+20
    chk("t1_tick20", 32'(sec_tick), 32'd1);
    chk("t1_secs20", 32'(secs_left), 32'd1);
    eots = 0;
    steps(9);                                 // RUN+29
    chk("t1_eot29", 32'(eots), 32'd0);
    step();                                   // RUN+30
    chk("t1_eot30", 32'(end_of_time), 32'd1);
    chk("t1_tick30", 32'(sec_tick), 32'd1);
    chk("t1_secs30", 32'(secs_left), 32'd0);
    chk("t1_run30", 32'(running), 32'd0);
    chk("t1_warn30", 32'(warning), 32'd0);
    step();                                   // RUN+31
    chk("t1_eot31", 32'(end_of_time), 32'd0);
    state_in = MENU_ST;
    step();

    // 2: pause for 7 cycles starting at RUN+4
    time_in = 4'd3; state_in = GAME_ST;
    step();                                   // RUN+0
    steps(4);                                 // RUN+4
    pause = 1'b1;
    ticks = 0;
    steps(7);                                 // RUN+11
    pause = 1'b0;
    chk("t2_pausetick", 32'(ticks), 32'd0);
    chk("t2_pauserun", 32'(running), 32'd1);
    chk("t2_pausesecs", 32'(secs_left), 32'd3);
    steps(6);                                 // RUN+17
    chk("t2_tick17", 32'(sec_tick), 32'd1);
    chk("t2_secs17", 32'(secs_left), 32'd2);
    eots = 0;
    steps(19);                                // RUN+36
    chk("t2_eot36", 32'(eots), 32'd0);
    step();                                   // RUN+37
    chk("t2_eot37", 32'(end_of_time), 32'd1);
    state_in = MENU_ST;
    step();

    // 3: bonus coincident with the final tick
    time_in = 4'd1; state_in = GAME_ST;
    step();                                   // RUN+0
    steps(9);                                 // RUN+9
    clicked_duck = 1'b1;
    step();                                   // RUN+10
    clicked_duck = 1'b0;
    chk("t3_secs", 32'(secs_left), 32'd2);
    chk("t3_tick", 32'(sec_tick), 32'd1);
    chk("t3_noeot", 32'(end_of_time), 32'd0);
    chk("t3_run", 32'(running), 32'd1);
    chk("t3_warn", 32'(warning), 32'd1);
    eots = 0;
    steps(19);                                // RUN+29
    chk("t3_eotearly", 32'(eots), 32'd0);
    step();                                   // RUN+30
    chk("t3_eot30", 32'(end_of_time), 32'd1);
    state_in = MENU_ST;
    step();

    // 4: saturation at 15
    time_in = 4'd14; state_in = GAME_ST;
    step();                                   // RUN+0
    chk("t4_load", 32'(secs_left), 32'd14);
    clicked_duck = 1'b1;
    step();
    chk("t4_sat1", 32'(secs_left), 32'd15);
    step();
    clicked_duck = 1'b0;
    chk("t4_sat2", 32'(secs_left), 32'd15);
    chk("t4_warn", 32'(warning), 32'd0);
    state_in = MENU_ST;
    step();

    // 5: leave GAME at secs_left=2, then asynchronous reset mid-second
    time_in = 4'd2; state_in = GAME_ST;
    step();
    chk("t5_secs", 32'(secs_left), 32'd2);
    chk("t5_warn", 32'(warning), 32'd1);
    state_in = MENU_ST;
    step();
    chk_all_zero("t5_leave");
    time_in = 4'd5; state_in = GAME_ST;
    step();
    steps(4);
    chk("t5_prerst", 32'(running), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk_all_zero("t5_rst");
    state_in = MENU_ST;
    step();
    rst = 1'b0;
    step();

    // 6: zero round length
    time_in = 4'd0; state_in = GAME_ST;
    step();
    chk("t6_eot", 32'(end_of_time), 32'd1);
    chk("t6_secs", 32'(secs_left), 32'd0);
    chk("t6_run", 32'(running), 32'd0);
    eots = 0;
    steps(6);
    chk("t6_norepulse", 32'(eots), 32'd0);
    chk("t6_doneidle", 32'(running), 32'd0);
    state_in = MENU_ST;
    step();
    chk_all_zero("t6_exit");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
